bsg_fsb_murn_boot_sequencer: RTL
================================

Name: bsg_fsb_murn_boot_sequencer

Overview:
Master-side controller that brings up and shuts down the murn nodes on an FSB ring. It issues switch-command packets so each node's gateway sees reset-assert, then reset-deassert, then enable, in that order. On request it later issues disable packets. It sits at the FSB master port, ahead of any data traffic, and is the sole source of switch commands for the ring.

Parameters:
width_p, 16, FSB packet width; fixed at 16.
nodes_p, 4, number of nodes on the ring, 1..16; node ids are 0..nodes_p-1.
reset_hold_p, 8, cycles between the last reset-assert handshake and the first reset-deassert packet, >=1.

Ports:
clk_i  in  1  clock.
reset_n_i  in  1  asynchronous, active-low reset.
start_i  in  1  single-cycle request to begin bring-up.
shutdown_i  in  1  single-cycle request to disable all nodes.
node_mask_i  in  nodes_p  1 = node participates; registered when start_i is accepted.
v_o  out  1  command packet valid.
data_o  out  width_p  command packet.
ready_i  in  1  FSB accepts packet.
busy_o  out  1  sequence in progress.
done_o  out  1  bring-up complete; nodes enabled.

Behaviour:
- Clock and reset: one clock, clk_i. reset_n_i is asynchronous and active-low. While reset_n_i=0 the state is IDLE and v_o=0, data_o=0, busy_o=0, done_o=0, counters=0 and mask=0. Outputs change immediately on reset assertion, not at the next edge.
- Packet format:
  - data_o[15:12] = dest node id.
  - data_o[11:9] = opcode: 3'b101 reset-assert, 3'b110 reset-deassert, 3'b010 enable, 3'b001 disable.
  - data_o[8:0] = 0.
- States: IDLE, ASSERT, HOLD, DEASSERT, ENABLE, DONE, DISABLE.
- Node iteration: in ASSERT, DEASSERT, ENABLE and DISABLE, a node index idx steps from 0 to nodes_p-1.
  - Mask bit 1: drive v_o=1 with the packet for node idx. Hold v_o and data_o stable until ready_i=1. Advance idx on the v_o&ready_i cycle.
  - Mask bit 0: spend exactly one cycle with v_o=0, then advance.
  - After node nodes_p-1 completes, reset idx to 0 and move to the next state.
- IDLE: start_i=1 registers node_mask_i and moves to ASSERT. The first packet is valid in the next cycle (1-cycle latency).
- ASSERT -> HOLD: the HOLD counter loads 0.
- HOLD: counts reset_hold_p cycles with v_o=0, then moves to DEASSERT.
- DEASSERT -> ENABLE -> DONE.
- DONE: done_o=1.
  - shutdown_i -> DISABLE.
  - start_i -> ASSERT (full restart); node_mask_i is re-registered.
  - If both are asserted, shutdown_i wins.
- DISABLE: sends opcode 001 to each masked node, then returns to IDLE with done_o=0.
- busy_o=1 in ASSERT, HOLD, DEASSERT, ENABLE and DISABLE. busy_o=0 in IDLE and DONE.
- Ignored requests, with no side effects:
  - start_i while busy_o=1.
  - shutdown_i in any state other than DONE.
  - node_mask_i changes after it has been registered.
- ready_i without v_o has no effect. v_o never drops without a handshake, except on reset.
- All-zero mask: no packets are sent. Sequence timing is still nodes_p idle cycles per phase plus HOLD, then DONE.
- ready_i held low: the FSM stalls indefinitely on the current packet.
- Mid-operation reset: the sequence is abandoned. After release the FSM is in IDLE and waits for a new start_i.

Test Plan:
- Reset, then start_i with mask 4'b1111 and ready_i=1.
  - Required: 4 packets 0x0A00, 0x1A00, 0x2A00, 0x3A00 on consecutive cycles starting 1 cycle after start.
  - Then 8 cycles v_o=0.
  - Then 0x0C00..0x3C00, then 0x0400..0x3400.
  - done_o=1 in the cycle after the last handshake; total 1+4+8+4+4 cycles to done.
- Mask 4'b0101, ready_i=1.
  - Required: ASSERT phase gives 0x0A00, idle cycle, 0x2A00, idle cycle.
  - Same pattern in later phases; done_o reached in the same cycle count as the first test.
- ready_i held 0 for 5 cycles on the first packet.
  - Required: v_o=1 and data_o=0x0A00 stable all 5 cycles; idx does not advance; sequence resumes on ready_i=1.
- In DONE, pulse shutdown_i with mask 4'b1111.
  - Required: packets 0x0200, 0x1200, 0x2200, 0x3200, then IDLE with done_o=0 and busy_o=0.
- start_i pulsed during HOLD, and shutdown_i pulsed during ENABLE.
  - Required: both ignored; packet stream identical to the first test.
- Assert reset_n_i=0 asynchronously mid-DEASSERT with v_o=1.
  - Required: v_o, busy_o and done_o go 0 before the next clock edge.
  - After release the block stays IDLE until start_i; a new start_i reproduces the first test's stream.

Source files
------------

// File: rtl/bsg_fsb_murn_boot_sequencer.sv
// FSB master-side boot sequencer: walks every masked murn node through
// reset-assert, reset-deassert and enable, and later disable on request.
module bsg_fsb_murn_boot_sequencer #(
  parameter int width_p      = 16,
  parameter int nodes_p      = 4,
  parameter int reset_hold_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               start_i,
  input  logic               shutdown_i,
  input  logic [nodes_p-1:0] node_mask_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i,
  output logic               busy_o,
  output logic               done_o
);

  localparam int idx_w_lp  = (nodes_p > 1) ? $clog2(nodes_p) : 1;
  localparam int hold_w_lp = (reset_hold_p > 1) ? $clog2(reset_hold_p) : 1;
  localparam logic [idx_w_lp-1:0]  last_idx_lp  = idx_w_lp'(nodes_p - 1);
  localparam logic [hold_w_lp-1:0] last_hold_lp = hold_w_lp'(reset_hold_p - 1);

  localparam logic [2:0] op_rst_assert_lp   = 3'b101;
  localparam logic [2:0] op_rst_deassert_lp = 3'b110;
  localparam logic [2:0] op_enable_lp       = 3'b010;
  localparam logic [2:0] op_disable_lp      = 3'b001;

  typedef enum logic [2:0] {
    IDLE, ASSERT, HOLD, DEASSERT, ENABLE, DONE, DISABLE
  } state_e;

  state_e               state_q, state_d;
  logic [idx_w_lp-1:0]  idx_q, idx_d;
  logic [hold_w_lp-1:0] hold_q, hold_d;
  logic [nodes_p-1:0]   mask_q, mask_d;

  logic                 iterating;
  logic [2:0]           opcode;
  state_e               phase_next;

  // NOTE: every output and _d is given a default before the case so no
  // path leaves a value unassigned; that is what keeps this block latch-free.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    mask_d     = mask_q;
    v_o        = 1'b0;
    data_o     = '0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    iterating  = 1'b0;
    opcode     = 3'b000;
    phase_next = state_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          mask_d  = node_mask_i;
          idx_d   = '0;
          state_d = ASSERT;
        end
      end
      ASSERT: begin
        busy_o     = 1'b1;
        iterating  = 1'b1;
        opcode     = op_rst_assert_lp;
        phase_next = HOLD;
      end
      HOLD: begin
        busy_o = 1'b1;
        if (hold_q == last_hold_lp) state_d = DEASSERT;
        else                        hold_d  = hold_q + hold_w_lp'(1);
      end
      DEASSERT: begin
        busy_o     = 1'b1;
        iterating  = 1'b1;
        opcode     = op_rst_deassert_lp;
        phase_next = ENABLE;
      end
      ENABLE: begin
        busy_o     = 1'b1;
        iterating  = 1'b1;
        opcode     = op_enable_lp;
        phase_next = DONE;
      end
      DONE: begin
        done_o = 1'b1;
        // Shutdown takes priority over a simultaneous restart request.
        if (shutdown_i) begin
          state_d = DISABLE;
        end else if (start_i) begin
          mask_d  = node_mask_i;
          state_d = ASSERT;
        end
      end
      DISABLE: begin
        busy_o     = 1'b1;
        iterating  = 1'b1;
        opcode     = op_disable_lp;
        phase_next = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Unmasked nodes burn one silent cycle; masked ones wait for the handshake.
    if (iterating) begin
      v_o = mask_q[idx_q];
      if (v_o) data_o = {4'(idx_q), opcode, 9'd0};
      if (!mask_q[idx_q] || ready_i) begin
        if (idx_q == last_idx_lp) begin
          idx_d   = '0;
          hold_d  = '0;
          state_d = phase_next;
        end else begin
          idx_d = idx_q + idx_w_lp'(1);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      mask_q  <= mask_d;
    end
  end

endmodule
